register_file: RTL
==================

Name: register_file

Overview:
- Architectural register file plus status-flag register for the execute path.
- Supplies the two ALU operands (source A, source B) and captures the writeback result, overflow bit and compare bit produced by the ALU.
- Sits directly upstream of the arithmetic logic unit and receives its outputs back at writeback.
- Provides same-cycle write-to-read bypass, a hardwired zero register, a sticky overflow flag and a compare flag used by branch logic.

Parameters:
DATA_WIDTH, package DATA_WIDTH, width of every register and data port
REG_COUNT, 16, number of architectural registers (power of two, >= 2)
ADDR_WIDTH, $clog2(REG_COUNT), register address width

Ports:
_clock  input  1  system clock, all state updates on rising edge
_reset  input  1  asynchronous, active-high reset
_readAddrA  input  ADDR_WIDTH  source A register index
_readAddrB  input  ADDR_WIDTH  source B register index
_writeEnable  input  1  commit _writeData to _writeAddr this cycle
_writeAddr  input  ADDR_WIDTH  destination register index
_writeData  input  DATA_WIDTH  ALU result to commit
_flagWriteEnable  input  1  commit _overflowIn/_compareIn this cycle
_overflowIn  input  1  ALU overflow bit
_compareIn  input  1  ALU compare bit
_clearOverflow  input  1  clear sticky overflow flag
valA  output  DATA_WIDTH  operand A to ALU
valB  output  DATA_WIDTH  operand B to ALU
overflowFlag  output  1  sticky overflow status
compareFlag  output  1  last committed compare bit
writeConflict  output  1  pulse: write attempted to register 0

Behaviour:
- Clock/reset: single clock _clock. _reset is asynchronous and active-high: on assertion, all registers, overflowFlag, compareFlag and writeConflict go to 0 immediately. State holds at 0 until the first rising edge after deassertion.
- Register 0:
  - Reads as 0 always.
  - A write to it is discarded.
  - writeConflict is registered and is 1 for exactly the cycle after such a write; otherwise 0.
- Register write: on a rising edge with _writeEnable=1 and _writeAddr!=0, regs[_writeAddr] <= _writeData.
- Reads: combinational (0-cycle latency) from _readAddrA/_readAddrB.
- Bypass:
  - If _writeEnable=1, _writeAddr!=0 and _writeAddr equals a read address, that read port returns _writeData in the same cycle.
  - Both ports may bypass simultaneously.
  - A read of register 0 never bypasses.
- Flags, on a rising edge with _flagWriteEnable=1:
  - compareFlag <= _compareIn.
  - overflowFlag <= overflowFlag | _overflowIn (sticky).
- Overflow clear:
  - _clearOverflow=1 forces overflowFlag <= 0 on the edge.
  - If _clearOverflow and _flagWriteEnable with _overflowIn=1 occur in the same cycle, the set wins: overflowFlag=1.
  - _clearOverflow does not affect compareFlag.
- Flag bypass: none. Flag outputs reflect registered state only (1-cycle latency).
- Independence: _writeEnable and _flagWriteEnable are independent; either may occur without the other.
- Reset mid-operation: any write in the reset cycle is lost. Outputs read 0 until new writes occur.
- Out-of-range: no address can exceed REG_COUNT-1 because REG_COUNT is a power of two.

Decomposition:
- Package: REG_COUNT, ADDR_WIDTH, REG_ZERO index constant, and a status_flags_t packed struct {overflow, compare}. DATA_WIDTH already lives there.
- One natural sub-module: register_file_read_port (address decode, zero check, bypass mux), instantiated twice for ports A and B.
- Register array and flag logic stay in the top module.

Test Plan:
- Reset: assert _reset asynchronously mid-cycle -> valA=valB=0, overflowFlag=compareFlag=writeConflict=0 immediately, before the next edge.
- Write/read: write 0x5A to r3, next cycle read A=r3, B=r3 -> valA=valB=0x5A.
- Bypass: write 0x11 to r7 while _readAddrA=7 and _readAddrB=7 in the same cycle -> valA=valB=0x11 that cycle; old value never visible.
- Zero register: write 0xFF to r0 -> valA with addr 0 stays 0; writeConflict=1 for one cycle, then 0.
- Sticky overflow:
  - _flagWriteEnable with _overflowIn=1, then with _overflowIn=0 -> overflowFlag stays 1.
  - _clearOverflow -> 0.
  - Simultaneous clear and _overflowIn=1 -> 1.
- Compare flag: _flagWriteEnable with _compareIn=1, then _compareIn=0 -> compareFlag 1 then 0. With _flagWriteEnable=0 and _compareIn=1 -> compareFlag unchanged.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared types and sizing for the execute-path register file.
// Data width, register count and the status flag layout live here.
package register_file_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_COUNT  = 16;
    localparam int ADDR_WIDTH = $clog2(REG_COUNT);
    localparam int REG_ZERO   = 0;

    typedef struct packed {
        logic overflow;
        logic compare;
    } status_flags_t;

endpackage

// File: rtl/register_file_read_port.sv
// One operand read port: selects a register, forces r0 to zero, bypasses the in-flight write.
// Latency: combinational, 0 cycles.
// Backpressure: none; the port always produces a value.
module register_file_read_port
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
    parameter int REG_COUNT  = register_file_pkg::REG_COUNT,
    parameter int ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic [ADDR_WIDTH-1:0] readAddr,
    input  logic                  writeEnable,
    input  logic [ADDR_WIDTH-1:0] writeAddr,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic [DATA_WIDTH-1:0] regs [REG_COUNT],
    output logic [DATA_WIDTH-1:0] readData
);

    logic isZero;
    logic bypassHit;

    assign isZero    = (readAddr == ADDR_WIDTH'(REG_ZERO));
    assign bypassHit = writeEnable && (writeAddr == readAddr);

    always_comb begin
        readData = regs[readAddr];
        if (isZero) begin
            readData = '0;
        end else if (bypassHit) begin
            readData = writeData;
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file with sticky overflow and compare status flags.
// Latency: reads 0 cycles (with write bypass), flags and writeConflict 1 cycle.
// Backpressure: none; every write and flag update is accepted on the edge.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
    parameter int REG_COUNT  = register_file_pkg::REG_COUNT,
    parameter int ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                  _clock,
    input  logic                  _reset,
    input  logic [ADDR_WIDTH-1:0] _readAddrA,
    input  logic [ADDR_WIDTH-1:0] _readAddrB,
    input  logic                  _writeEnable,
    input  logic [ADDR_WIDTH-1:0] _writeAddr,
    input  logic [DATA_WIDTH-1:0] _writeData,
    input  logic                  _flagWriteEnable,
    input  logic                  _overflowIn,
    input  logic                  _compareIn,
    input  logic                  _clearOverflow,
    output logic [DATA_WIDTH-1:0] valA,
    output logic [DATA_WIDTH-1:0] valB,
    output logic                  overflowFlag,
    output logic                  compareFlag,
    output logic                  writeConflict
);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    status_flags_t         flags;
    logic                  writeToZero;
    logic                  writeValid;

    assign writeToZero = _writeEnable && (_writeAddr == ADDR_WIDTH'(REG_ZERO));
    assign writeValid  = _writeEnable && !writeToZero;

    // r0 is never written, so its storage stays at the reset value of zero.
    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (writeValid) begin
            regs[_writeAddr] <= _writeData;
        end
    end

    // A same-cycle overflow set takes priority over a clear.
    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            flags         <= '0;
            writeConflict <= 1'b0;
        end else begin
            flags.overflow <= (flags.overflow && !_clearOverflow)
                            || (_flagWriteEnable && _overflowIn);
            if (_flagWriteEnable) begin
                flags.compare <= _compareIn;
            end
            writeConflict <= writeToZero;
        end
    end

    assign overflowFlag = flags.overflow;
    assign compareFlag  = flags.compare;

    register_file_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .REG_COUNT (REG_COUNT),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_portA (
        .readAddr   (_readAddrA),
        .writeEnable(writeValid),
        .writeAddr  (_writeAddr),
        .writeData  (_writeData),
        .regs       (regs),
        .readData   (valA)
    );

    register_file_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .REG_COUNT (REG_COUNT),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_portB (
        .readAddr   (_readAddrB),
        .writeEnable(writeValid),
        .writeAddr  (_writeAddr),
        .writeData  (_writeData),
        .regs       (regs),
        .readData   (valB)
    );

endmodule
